sfifo_prog: RTL
===============

Name: sfifo_prog

Overview:
- Single-clock, parametrised FIFO; the synchronous successor to the team's dual-clock FIFO, used where producer and consumer share one clock.
- Adds the following over the previous generation:
  - arbitrary depth, not limited to powers of two
  - occupancy count
  - runtime-programmable almost-full and almost-empty flags
  - selectable standard or first-word-fall-through (FWFT) read mode
  - sticky overflow/underflow with explicit clear

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries (>=2; any integer).
- PTR_WIDTH, $clog2(DEPTH), read/write pointer width. Derived; do not override.
- CNT_WIDTH, $clog2(DEPTH+1), width of count and thresholds. Derived.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on posedge.
- res  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- wdata  in  WIDTH  write data.
- rd_en  in  1  read request (pop).
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata valid qualifier.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- almost_full  out  1  count>=af_thresh.
- almost_empty  out  1  count<=ae_thresh.
- af_thresh  in  CNT_WIDTH  almost-full threshold; sampled every cycle.
- ae_thresh  in  CNT_WIDTH  almost-empty threshold; sampled every cycle.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow/underflow.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset (res=1 at posedge):
  - wr_ptr=rd_ptr=0, count=0.
  - rdata=0, rvalid=0, overflow=0, underflow=0, parity_err=0.
  - Storage contents are not cleared. Memory contents are don't-care after reset.
  - Reset overrides every other input in the same cycle, including mid-burst; in-flight reads are dropped.
- Flags are derived combinationally from count and the threshold inputs:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count>=af_thresh)
  - almost_empty = (count<=ae_thresh)
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
- Read acceptance: rd_acc = rd_en & ~empty.
- Full with wr_en & rd_en: both are accepted, count is unchanged, no overflow.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow set, count becomes 1.
- Pointers: increment on acceptance and wrap from DEPTH-1 to 0. Non-power-of-two depth requires an explicit compare, not natural overflow.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It never leaves 0..DEPTH.
- overflow: set on wr_en & ~wr_acc.
- underflow: set on rd_en & empty.
- Sticky-flag clear: err_clr clears both flags the next cycle. If a set event and err_clr occur in the same cycle, the set wins.
- Standard mode (FWFT=0):
  - On rd_acc, rdata <= mem[rd_ptr] and rvalid=1 in the next cycle, for exactly one cycle per accepted read.
  - rdata holds its last value otherwise. Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rdata = mem[rd_ptr] combinationally while ~empty; rvalid = ~empty.
  - rd_en acknowledges and pops the shown word; the next word appears the following cycle.
  - A word written into an empty FIFO is visible at rdata the cycle after the write.
- Write to an address and read of the same address in the same cycle cannot occur, except in the full+read+write case, where the read returns the old word (read-before-write).
- Thresholds: af_thresh>DEPTH means almost_full is never asserted. ae_thresh=0 is equivalent to empty.

Optional Feature:
- Macro: SFIFO_PARITY_EN.
- When defined:
  - Storage widens to WIDTH+1; an even-parity bit of wdata is stored on each write.
  - On each read (standard: the cycle rvalid=1; FWFT: whenever rvalid=1), parity_err=1 if the stored parity mismatches the recomputed parity.
  - In standard mode parity_err is registered alongside rdata; in FWFT mode it is combinational.
- When undefined: storage is WIDTH bits and parity_err is tied to 0.
- The port list is identical in both builds.

Decomposition:
- Shared package/header sfifo_pkg: clog2 helper function, FIFO_MODE_STD=0 / FIFO_MODE_FWFT=1 constants, and an even-parity function.
- One sub-module, sfifo_mem: DEPTH x (WIDTH or WIDTH+1) array with one synchronous write port and one read port. The read port is registered or combinational, selected by the FWFT parameter.
- Pointers, count, flags and the sticky logic stay in sfifo_prog.

Test Plan:
- Fill/drain, DEPTH=16, FWFT=0: write 0x00..0x0F -> full=1, count=16. Read 16 times -> rdata 0x00..0x0F, each 1 cycle after rd_en with rvalid pulses; empty=1 at end.
- Overflow/clear: while full, write 0xAA -> overflow=1, count stays 16, 0xAA is never read. Pulse err_clr -> overflow=0 next cycle.
- Simultaneous access at both boundaries:
  - Full plus wr_en&rd_en -> count stays 16, the oldest word is read, the new word is stored.
  - Empty plus both -> underflow=1, count=1.
- Thresholds and odd depth, DEPTH=5, af_thresh=4, ae_thresh=1:
  - count 1 -> almost_empty=1.
  - count 4 -> almost_full=1, full=0.
  - Pointers wrap after entry 4 over 3 fill/drain passes with no data loss.
- FWFT=1: write 0x5A into an empty FIFO -> next cycle rvalid=1, rdata=0x5A without rd_en. Pulse rd_en -> empty=1, rvalid=0.
- Reset mid-operation: assert res with count=7 -> next cycle count=0, empty=1, rvalid=0, overflow=underflow=0. A subsequent write/read returns the new data only.
- With SFIFO_PARITY_EN, force-flip one stored bit -> parity_err=1 on that read only.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared helpers for the single-clock programmable FIFO:
// sizing, read-mode codes and the stored-word parity function.
package sfifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    localparam int PAR_MAX_W      = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sfifo_prog_if.sv
// Producer/consumer-facing signal bundle of sfifo_prog; the FIFO takes the slave side.
interface sfifo_prog_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 5
);
    logic                 wr_en;
    logic [WIDTH-1:0]     wdata;
    logic                 rd_en;
    logic [WIDTH-1:0]     rdata;
    logic                 rvalid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_WIDTH-1:0] af_thresh;
    logic [CNT_WIDTH-1:0] ae_thresh;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;
    logic                 underflow;
    logic                 err_clr;
    logic                 parity_err;

    modport master (
        output wr_en, wdata, rd_en, af_thresh, ae_thresh, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, parity_err
    );

    modport slave (
        input  wr_en, wdata, rd_en, af_thresh, ae_thresh, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, parity_err
    );
endinterface

// File: rtl/sfifo_mem.sv
// FIFO storage: one synchronous write port, one read port that is registered
// (standard mode, reset to zero) or combinational (first-word-fall-through).
module sfifo_mem
    import sfifo_pkg::*;
#(
    parameter int MW        = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [MW-1:0]        wdata,
    input  logic                 re,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [MW-1:0]        rdata
);

    logic [MW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_comb
        logic unused_rd;
        assign unused_rd = ^{res, re};
        assign rdata     = mem_q[raddr];
    end else begin : g_reg
        // Non-blocking read of the old word gives read-before-write on a shared address.
        logic [MW-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (res)     rdata_q <= '0;
            else if (re) rdata_q <= mem_q[raddr];
        end
        assign rdata = rdata_q;
    end

endmodule

// File: rtl/sfifo_prog.sv
// Single-clock FIFO with any depth, occupancy count, programmable almost flags,
// sticky overflow/underflow and standard/FWFT read. Stored parity: SFIFO_PARITY_EN.
module sfifo_prog
    import sfifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = clog2(DEPTH),
    parameter int CNT_WIDTH = clog2(DEPTH + 1),
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic         clk,
    input  logic         res,
    sfifo_prog_if.slave  bus
);

`ifdef SFIFO_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic                 full, empty, rd_acc, wr_acc, rvalid;
    logic [MW-1:0]        mem_wdata, mem_rdata;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign rd_acc = bus.rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_acc = bus.wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (wr_acc & ~rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc & ~wr_acc) count_d = count_q - 1'b1;
        ovf_d = (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.err_clr);
        udf_d = (bus.rd_en & empty)   | (udf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sfifo_mem #(
        .MW        (MW),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .FWFT      (FWFT)
    ) u_mem (
        .clk   (clk),
        .res   (res),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rvalid    = ~empty;
        assign bus.rdata = rvalid ? mem_rdata[WIDTH-1:0] : '0;
    end else begin : g_std
        logic rvalid_q;
        always_ff @(posedge clk) begin
            if (res) rvalid_q <= 1'b0;
            else     rvalid_q <= rd_acc;
        end
        assign rvalid    = rvalid_q;
        assign bus.rdata = mem_rdata[WIDTH-1:0];
    end

`ifdef SFIFO_PARITY_EN
    assign mem_wdata      = {even_parity(PAR_MAX_W'(bus.wdata)), bus.wdata};
    assign bus.parity_err = rvalid &
        (mem_rdata[WIDTH] != even_parity(PAR_MAX_W'(mem_rdata[WIDTH-1:0])));
`else
    assign mem_wdata      = bus.wdata;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rvalid       = rvalid;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
